// File: rtl/escaner_teclado_pkg.sv
// Shared constants and helpers for the keypad scanner: matrix geometry and the
// key-event record handed from the scanner to its consumer.
package escaner_teclado_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 8;
    localparam int CODE_W   = 5;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              press;
    } key_event_t;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [2:0] lowest_row(input logic [NUM_ROWS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (v[r]) idx = r[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/escaner_teclado_antirrebote_columna.sv
// Debounce for one keypad column: remembers the previous row sample, counts how
// many consecutive samples matched, and accepts a new key state once it is stable.
module antirrebote_columna
    import escaner_teclado_pkg::*;
#(
    parameter logic [2:0] DEBOUNCE = 3'd4
) (
    input  logic                clk12Mhz,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [NUM_ROWS-1:0] sample,
    output logic [NUM_ROWS-1:0] keys,
    output logic                upd,
    output logic [NUM_ROWS-1:0] chg
);

    logic [NUM_ROWS-1:0] prev_q, prev_d;
    logic [NUM_ROWS-1:0] keys_q, keys_d;
    logic [2:0]          cnt_q, cnt_d;

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        keys_d = keys_q;
        upd    = 1'b0;
        if (sample_en) begin
            prev_d = sample;
            if (sample == prev_q) begin
                cnt_d = (cnt_q == DEBOUNCE) ? cnt_q : cnt_q + 3'd1;
            end else begin
                cnt_d = 3'd1;
            end
            if (cnt_d == DEBOUNCE && sample != keys_q) begin
                keys_d = sample;
                upd    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk12Mhz) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q  <= 3'd0;
            keys_q <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            keys_q <= keys_d;
        end
    end

    assign keys = keys_q;
    assign chg  = keys_q ^ sample;

endmodule

// File: rtl/escaner_teclado.sv
// 4x8 keypad scanner: walks an active-low column drive, debounces each column,
// and reports one key event at a time through a valid/ack handshake.
module escaner_teclado
    import escaner_teclado_pkg::*;
#(
    parameter logic [11:0] SCAN_DIV = 12'd1024,
    parameter logic [2:0]  DEBOUNCE = 3'd4
) (
    input  logic        clk12Mhz,
    input  logic        rst,
    output logic [3:0]  kcol,
    input  logic [7:0]  krow,
    output logic [7:0]  keys1,
    output logic [7:0]  keys2,
    output logic [7:0]  keys3,
    output logic [7:0]  keys4,
    output logic        ev_valid,
    output logic [4:0]  ev_code,
    output logic        ev_press,
    input  logic        ev_ack,
    output logic        overrun
);

    logic [NUM_ROWS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic                run_q, run_d;
    logic [11:0]         div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic                ev_valid_q, ev_valid_d;
    key_event_t          ev_q, ev_d;
    logic                overrun_q, overrun_d;

    logic [NUM_COLS-1:0] samp_en;
    logic [NUM_COLS-1:0] upd;
    logic [NUM_ROWS-1:0] keys_c [NUM_COLS];
    logic [NUM_ROWS-1:0] chg    [NUM_COLS];
    logic [NUM_ROWS-1:0] chg_sel;
    logic [2:0]          row;
    logic                new_ev;
    logic                multi;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        antirrebote_columna #(.DEBOUNCE(DEBOUNCE)) u_col (
            .clk12Mhz  (clk12Mhz),
            .rst       (rst),
            .sample_en (samp_en[c]),
            .sample    (sync2_q),
            .keys      (keys_c[c]),
            .upd       (upd[c]),
            .chg       (chg[c])
        );
    end

    always_comb begin
        // Rows are inverted on entry so the synchronizer holds 1 = pressed.
        sync1_d    = ~krow;
        sync2_d    = sync1_q;
        run_d      = 1'b1;
        div_d      = div_q;
        col_d      = col_q;
        samp_en    = '0;
        if (run_q) begin
            if (div_q == SCAN_DIV - 12'd1) begin
                div_d   = 12'd0;
                col_d   = col_q + 2'd1;
                samp_en = 4'b0001 << col_q;
            end else begin
                div_d = div_q + 12'd1;
            end
        end

        // Only the column being sampled can report an update this cycle.
        new_ev     = |upd;
        chg_sel    = chg[col_q];
        row        = lowest_row(chg_sel);
        multi      = (chg_sel & (chg_sel - 8'd1)) != 8'd0;

        ev_valid_d = ev_valid_q;
        ev_d       = ev_q;
        overrun_d  = overrun_q;
        if (new_ev && (!ev_valid_q || ev_ack)) begin
            ev_valid_d  = 1'b1;
            ev_d.code   = {col_q, row};
            ev_d.press  = sync2_q[row];
        end else if (ev_ack) begin
            ev_valid_d = 1'b0;
        end
        if (new_ev && (multi || (ev_valid_q && !ev_ack))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk12Mhz) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            run_q      <= 1'b0;
            div_q      <= 12'd0;
            col_q      <= 2'd0;
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            run_q      <= run_d;
            div_q      <= div_d;
            col_q      <= col_d;
            ev_valid_q <= ev_valid_d;
            ev_q       <= ev_d;
            overrun_q  <= overrun_d;
        end
    end

    assign kcol     = run_q ? ~(4'b0001 << col_q) : 4'b1111;
    assign keys1    = keys_c[0];
    assign keys2    = keys_c[1];
    assign keys3    = keys_c[2];
    assign keys4    = keys_c[3];
    assign ev_valid = ev_valid_q;
    assign ev_code  = ev_q.code;
    assign ev_press = ev_q.press;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_escaner_teclado.sv
// Bench for the keypad scanner with a small key-matrix model driving krow from kcol
// and a queue of expected key events.
module tb_escaner_teclado;

    localparam logic [11:0] SD = 12'd8;
    localparam logic [2:0]  DB = 3'd3;

    logic       clk12Mhz = 1'b0;
    logic       rst      = 1'b1;
    logic       ev_ack   = 1'b0;
    logic [7:0] krow;
    logic [3:0] kcol;
    logic [7:0] keys1, keys2, keys3, keys4;
    logic       ev_valid;
    logic [4:0] ev_code;
    logic       ev_press;
    logic       overrun;

    logic [7:0] pressed [4];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0] code;
        logic       press;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         col;
        int         row;
        bit         press;
        logic [7:0] keys_exp;
        int         code_exp;
    } vec_t;
    vec_t vecs[8];

    escaner_teclado #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk12Mhz (clk12Mhz),
        .rst      (rst),
        .kcol     (kcol),
        .krow     (krow),
        .keys1    (keys1),
        .keys2    (keys2),
        .keys3    (keys3),
        .keys4    (keys4),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_press (ev_press),
        .ev_ack   (ev_ack),
        .overrun  (overrun)
    );

    always #5 clk12Mhz = ~clk12Mhz;

    // A pressed key pulls its row low only while its column is driven.
    always_comb begin
        krow = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            if (!kcol[c]) krow = krow & ~pressed[c];
        end
    end

    task automatic tick();
        @(posedge clk12Mhz);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] keys_of(input int c);
        case (c)
            0:       return keys1;
            1:       return keys2;
            2:       return keys3;
            default: return keys4;
        endcase
    endfunction

    task automatic wait_ev(input string name, input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (!ev_valid && n < budget) begin
            tick();
            n++;
        end
        if (!ev_valid) begin
            chk({name, " event timeout"}, ev_valid, 1);
            if (sb.size() != 0) e = sb.pop_front();
        end else if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event code %0d press %0d", name, ev_code, ev_press);
        end else begin
            e = sb.pop_front();
            chk({name, " ev_code"}, ev_code, e.code);
            chk({name, " ev_press"}, ev_press, e.press);
        end
    endtask

    task automatic ack_ev(input string name);
        ev_ack = 1'b1;
        tick();
        ev_ack = 1'b0;
        chk({name, " ev_valid after ack"}, ev_valid, 0);
    endtask

    task automatic wait_kcol(input logic [3:0] v);
        int n;
        n = 0;
        while (kcol !== v && n < 64) begin
            tick();
            n++;
        end
        chk("kcol reached", kcol, v);
    endtask

    initial begin
        logic [3:0] ek;
        bit         seen;

        for (int c = 0; c < 4; c++) pressed[c] = 8'h00;
        vecs[0] = '{1, 2, 1'b1, 8'h04, 10};
        vecs[1] = '{1, 2, 1'b0, 8'h00, 10};
        vecs[2] = '{2, 7, 1'b1, 8'h80, 23};
        vecs[3] = '{0, 0, 1'b1, 8'h01, 0};
        vecs[4] = '{0, 0, 1'b0, 8'h00, 0};
        vecs[5] = '{2, 7, 1'b0, 8'h00, 23};
        vecs[6] = '{3, 0, 1'b1, 8'h01, 24};
        vecs[7] = '{3, 0, 1'b0, 8'h00, 24};

        // Reset mid-scan, then watch the column walk.
        repeat (3) tick();
        rst = 1'b0;
        repeat (13) tick();
        rst = 1'b1;
        tick();
        chk("rst kcol", kcol, 4'b1111);
        chk("rst keys", {keys1, keys2, keys3, keys4}, 0);
        chk("rst ev_valid", ev_valid, 0);
        chk("rst ev_code", ev_code, 0);
        chk("rst ev_press", ev_press, 0);
        chk("rst overrun", overrun, 0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            ek = ~(4'b0001 << (i / 8));
            chk($sformatf("scan kcol cycle %0d", i), kcol, ek);
        end

        // Single-key presses and releases.
        for (int i = 0; i < 8; i++) begin
            pressed[vecs[i].col][vecs[i].row] = vecs[i].press;
            sb.push_back('{code: vecs[i].code_exp[4:0], press: vecs[i].press});
            wait_ev($sformatf("vec%0d", i), 200);
            chk($sformatf("vec%0d keys", i), keys_of(vecs[i].col), vecs[i].keys_exp);
            chk($sformatf("vec%0d overrun", i), overrun, 0);
            ack_ev($sformatf("vec%0d", i));
        end

        // Contact bounce once per full scan never settles.
        seen = 1'b0;
        for (int s = 0; s < 10; s++) begin
            pressed[0][7] = ~pressed[0][7];
            repeat (32) begin
                tick();
                if (ev_valid) seen = 1'b1;
            end
            chk($sformatf("bounce keys1 scan %0d", s), keys1, 8'h00);
        end
        repeat (128) begin
            tick();
            if (ev_valid) seen = 1'b1;
        end
        chk("bounce no event", seen, 0);
        chk("bounce keys1 final", keys1, 8'h00);

        // Two rows of one column change together.
        pressed[3] = 8'h22;
        sb.push_back('{code: 5'd25, press: 1'b1});
        wait_ev("multi press", 200);
        chk("multi keys4", keys4, 8'h22);
        chk("multi overrun", overrun, 1);
        ack_ev("multi press");
        pressed[3] = 8'h00;
        sb.push_back('{code: 5'd25, press: 1'b0});
        wait_ev("multi release", 200);
        chk("multi release keys4", keys4, 8'h00);
        ack_ev("multi release");

        rst = 1'b1;
        tick();
        chk("rst2 overrun", overrun, 0);
        rst = 1'b0;

        // Second event while the first is still pending.
        pressed[0][0] = 1'b1;
        sb.push_back('{code: 5'd0, press: 1'b1});
        wait_ev("ovr first", 200);
        pressed[2][4] = 1'b1;
        repeat (160) tick();
        chk("ovr ev_valid", ev_valid, 1);
        chk("ovr ev_code kept", ev_code, 0);
        chk("ovr ev_press kept", ev_press, 1);
        chk("ovr keys3", keys3, 8'h10);
        chk("ovr overrun", overrun, 1);

        // Reset with an event pending discards it.
        for (int c = 0; c < 4; c++) pressed[c] = 8'h00;
        rst = 1'b1;
        tick();
        chk("rst3 ev_valid", ev_valid, 0);
        chk("rst3 overrun", overrun, 0);
        rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        repeat (200) begin
            tick();
            if (ev_valid) seen = 1'b1;
        end
        chk("rst3 no event", seen, 0);

        // Ack lands in the very cycle the next event is registered.
        pressed[0][0] = 1'b1;
        sb.push_back('{code: 5'd0, press: 1'b1});
        wait_ev("same-cycle first", 200);
        wait_kcol(4'b1011);
        pressed[1][3] = 1'b1;
        sb.push_back('{code: 5'd11, press: 1'b1});
        for (int k = 0; k < 3; k++) begin
            wait_kcol(4'b1101);
            if (k < 2) begin
                repeat (8) tick();
            end else begin
                repeat (7) tick();
                chk("same-cycle before ack", ev_code, 0);
                ev_ack = 1'b1;
                tick();
                ev_ack = 1'b0;
            end
        end
        chk("same-cycle ev_valid", ev_valid, 1);
        wait_ev("same-cycle second", 0);
        chk("same-cycle keys2", keys2, 8'h08);
        chk("same-cycle overrun", overrun, 0);
        ack_ev("same-cycle second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12'd1024: clk12Mhz cycles each column is driven; legal range 4..4095.
REQ-002 SHALL have parameter DEBOUNCE, default 3'd4: consecutive identical samples of a column needed to accept a new state; legal range 1..7.
REQ-003 SHALL have port clk12Mhz  input  1  system clock, 12 MHz.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port kcol  output  4  column drive, active-low; at most one bit low.
REQ-006 SHALL have port krow  input  8  raw row sense, active-low (external pull-ups); asynchronous.
REQ-007 SHALL have ports keys1, keys2, keys3, keys4  output  8 each  debounced key state of columns 0..3; bit r = 1 means row r pressed.
REQ-008 SHALL have port ev_valid  output  1  key event pending.
REQ-009 SHALL have port ev_code  output  5  event key index = col*8 + row.
REQ-010 SHALL have port ev_press  output  1  1 = press event, 0 = release event.
REQ-011 SHALL have port ev_ack  input  1  consumer acknowledge, one cycle.
REQ-012 SHALL have port overrun  output  1  sticky: an event was lost.

Function
REQ-013 SHALL pass krow through a 2-flop synchronizer, then invert it so that 1 = pressed.
REQ-014 SHALL drive columns in order 0,1,2,3,0,...; column c: kcol = ~(4'b0001 << c), held exactly SCAN_DIV cycles; full scan = 4*SCAN_DIV cycles.
REQ-015 SHALL sample the synchronized rows once per dwell, on the last cycle of that dwell (divider = SCAN_DIV-1), then advance to the next column on the same edge.
REQ-016 SHALL keep, per column, the previous sample and a stability counter: equal sample -> counter increments, saturating at DEBOUNCE; differing sample -> counter = 1.
REQ-017 SHALL load keysN from the sample when the counter reaches DEBOUNCE and the sample differs from keysN; keysN SHALL never change otherwise.
REQ-018 SHALL compute, on a keysN update, changed = old ^ new; the lowest set row r yields an event with code = N*8 + r and press = new[r].
REQ-019 SHALL set overrun for every additional changed bit in the same update beyond the lowest; keysN still takes the full new value.
REQ-020 SHALL, when no event is pending, or ev_ack is high in the same cycle, register the event: ev_valid = 1 from the next cycle, with ev_code and ev_press stable until acknowledged.
REQ-021 SHALL set overrun and drop the new event if an event arrives while ev_valid = 1 and ev_ack = 0.
REQ-022 SHALL clear ev_valid the cycle after ev_ack when no new event arrives; ev_ack while ev_valid = 0 SHALL be ignored.
REQ-023 SHALL hold overrun at 1 until rst.
REQ-024 SHALL deliver a held press within (DEBOUNCE+1)*4*SCAN_DIV + 4 cycles of the krow edge.

Reset
REQ-025 SHALL, while rst is sampled high: kcol = 4'b1111, keys1..keys4 = 8'h00, ev_valid = 0, ev_code = 0, ev_press = 0, overrun = 0, divider = 0, column = 0, all stability counters = 0, synchronizer = 0 (nothing pressed).
REQ-026 SHALL drive kcol = 4'b1110 in the first cycle after rst deasserts, beginning a full column-0 dwell.
REQ-027 SHALL, on rst mid-dwell or with ev_valid = 1, abort the scan and discard the pending event, with no event emitted for the aborted state.

Structure
REQ-028 SHALL take the constants NUM_COLS = 4, NUM_ROWS = 8 and CODE_W = 5 from the shared peripherals package/include file.
REQ-029 SHALL instantiate the per-column debounce (previous sample, counter, accepted state) as sub-module antirrebote_columna, four instances.
REQ-030 SHALL keep the column scan counter, event arbitration and handshake in the top level.

Verification (SCAN_DIV=8, DEBOUNCE=3)
REQ-031 SHALL check reset: assert rst mid-scan -> next cycle kcol=1111 and all outputs 0; release -> kcol=1110 for 8 cycles, then 1101, 1011, 0111.
REQ-032 SHALL check a clean press: col1 row2 held low -> keys2=8'h04, ev_valid=1, ev_code=10, ev_press=1 within 132 cycles; ack -> ev_valid=0; release -> release event with ev_code=10 and ev_press=0.
REQ-033 SHALL check bounce: col0 row7 toggling every full scan (32 cycles) for 10 scans -> keys1 stays 8'h00 and no event.
REQ-034 SHALL check a multi-key update: col3 rows 1 and 5 pressed together -> keys4=8'h22, ev_code=25, overrun=1.
REQ-035 SHALL check overrun: press col0 row0 without ack, then press col2 row4 -> ev_code stays 0 and overrun=1; ack in the same cycle a new event arrives -> new event accepted and overrun unchanged.
